// File: rtl/johnson_compare_scheduler.sv
// ---------------------------------------------------------------------------
// johnson_compare_scheduler
//
// Shares one Johnson counter/comparator between NREQ requesters. Pending
// requests are granted round-robin. For the granted requester the counter runs
// from zero until it equals the latched target code (o_done pulse) or until
// every one of the 2*WIDTH Johnson states has been visited without a match
// (o_err pulse, the target is not a Johnson code). A run can be abandoned with
// i_abort.
//
// Ports
//   i_clk     in   1           clock, rising edge
//   i_rst     in   1           asynchronous reset, active-high
//   i_req     in   NREQ        request levels, held until the matching o_gnt bit
//   i_target  in   NREQ*WIDTH  target codes, slice r = [r*WIDTH +: WIDTH]
//   i_abort   in   1           synchronous abort of the current run
//   o_gnt     out  NREQ        one-hot single-cycle grant pulse
//   o_busy    out  1           high while a run is in progress
//   o_count   out  WIDTH       current Johnson counter value
//   o_done    out  1           single-cycle pulse: counter matched target
//   o_err     out  1           single-cycle pulse: no match in 2*WIDTH states
//   o_id      out  IDW         requester index of the current/last run
// ---------------------------------------------------------------------------
module johnson_compare_scheduler #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 2,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_target,
  input  logic                    i_abort,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_busy,
  output logic [WIDTH-1:0]        o_count,
  output logic                    o_done,
  output logic                    o_err,
  output logic [IDW-1:0]          o_id
);

  // Step counter only has to reach 2*WIDTH-1, where the run always exits.
  localparam int SW   = $clog2(2 * WIDTH);
  localparam int LAST = 2 * WIDTH - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt,   cnt_nxt;
  logic [WIDTH-1:0] tgt,   tgt_nxt;
  logic [SW-1:0]    step,  step_nxt;
  logic [IDW-1:0]   ptr,   ptr_nxt;
  logic [IDW-1:0]   id_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             done_nxt;
  logic             err_nxt;

  // Round-robin pick: first requester at or after ptr+1, wrapping.
  logic             found;
  logic [IDW-1:0]   win;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && i_req[(int'(ptr) + off) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + off) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    step_nxt  = step;
    ptr_nxt   = ptr;
    id_nxt    = o_id;
    gnt_nxt   = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt      = '0;
          gnt_nxt[win] = 1'b1;
          tgt_nxt      = i_target[int'(win)*WIDTH +: WIDTH];
          id_nxt       = win;
          ptr_nxt      = win;
          cnt_nxt      = '0;
          step_nxt     = '0;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (cnt == tgt) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (step == SW'(LAST)) begin
          // All 2*WIDTH states seen without a match: target is not a Johnson code.
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt  = {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
          step_nxt = step + SW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt    <= '0;
      step   <= '0;
      ptr    <= IDW'(NREQ - 1);
      o_id   <= '0;
      o_gnt  <= '0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tgt    <= tgt_nxt;
      step   <= step_nxt;
      ptr    <= ptr_nxt;
      o_id   <= id_nxt;
      o_gnt  <= gnt_nxt;
      o_done <= done_nxt;
      o_err  <= err_nxt;
    end
  end

  assign o_busy  = (state == RUN);
  assign o_count = cnt;

endmodule

// File: tb/tb_johnson_compare_scheduler.sv
// ---------------------------------------------------------------------------
// tb_johnson_compare_scheduler
//
// Scoreboard bench. A driver issues requests (directed cases then random) and
// pushes the expected outcome of each run into a queue, computed from a
// reference model: Johnson codes built arithmetically, a lookup for the target
// index, and a round-robin pointer. A monitor samples the DUT on the falling
// edge, matches every grant and every end of run against the queue head.
// ---------------------------------------------------------------------------
module tb_johnson_compare_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NST   = 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] target;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic                  done;
  logic                  err;
  logic [IDW-1:0]        id;

  johnson_compare_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_target (target),
    .i_abort  (abort),
    .o_gnt    (gnt),
    .o_busy   (busy),
    .o_count  (count),
    .o_done   (done),
    .o_err    (err),
    .o_id     (id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_DONE = 0, K_ERR = 1, K_ABORT = 2} kind_t;
  typedef struct {
    int               rid;
    int               kind;
    int               lat;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   m_ptr = NREQ - 1;

  // k-th Johnson code: k ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [WIDTH-1:0] jcode(input int k);
    int v;
    if (k <= WIDTH) v = (1 << k) - 1;
    else            v = ((1 << WIDTH) - 1) & ~((1 << (k - WIDTH)) - 1);
    return v[WIDTH-1:0];
  endfunction

  function automatic int jindex(input logic [WIDTH-1:0] c);
    for (int k = 0; k < NST; k++) if (jcode(k) == c) return k;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int off = 1; off <= NREQ; off++)
      if (r[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Called on a falling edge with the DUT idle. ab >= 0 aborts the run ab
  // cycles after the grant is seen; caller keeps ab below the target index.
  task automatic do_txn(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] tg,
                        input int ab);
    exp_t             e;
    int               w;
    int               k;
    logic [WIDTH-1:0] t;
    bit               seen;
    w = rr_pick(r);
    t = tg[w*WIDTH +: WIDTH];
    k = jindex(t);
    e.rid = w;
    if (ab >= 0) begin
      e.kind = K_ABORT; e.lat = ab + 1;  e.cnt = jcode(ab);
    end else if (k >= 0) begin
      e.kind = K_DONE;  e.lat = k + 1;   e.cnt = t;
    end else begin
      e.kind = K_ERR;   e.lat = NST;     e.cnt = jcode(NST - 1);
    end
    sb.push_back(e);
    m_ptr  = w;
    req    = r;
    target = tg;
    seen   = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt != '0);
    end
    if (!seen) begin
      timeout("grant_wait");
      void'(sb.pop_back());
      req = '0;
      return;
    end
    // Inputs changing during the run must have no effect.
    req    = NREQ'($urandom);
    target = (NREQ*WIDTH)'($urandom);
    if (ab >= 0) begin
      repeat (ab) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3 * NST && !seen; i++) begin
      if (!busy) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) timeout("run_end_wait");
    req = '0;
  endtask

  // ---------------- monitor ----------------
  int mon_cyc     = 0;
  int mon_gnt_cyc = 0;
  bit mon_active  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      mon_cyc++;
      if (gnt != '0 || done || err)
        check("single_pulse", 32'($countones({|gnt, done, err})), 32'd1);
      if (gnt != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          e = sb[0];
          check("gnt_onehot", 32'(gnt), 32'(1 << e.rid));
          check("gnt_id", 32'(id), 32'(e.rid));
          check("gnt_busy", 32'(busy), 32'd1);
          mon_gnt_cyc = mon_cyc;
          mon_active  = 1'b1;
        end
      end else if (mon_active && !busy) begin
        e    = sb.pop_front();
        kind = done ? K_DONE : (err ? K_ERR : K_ABORT);
        check("end_kind", 32'(kind), 32'(e.kind));
        check("end_latency", 32'(mon_cyc - mon_gnt_cyc), 32'(e.lat));
        check("end_count", 32'(count), 32'(e.cnt));
        check("end_id", 32'(id), 32'(e.rid));
        mon_active = 1'b0;
      end else if (!mon_active && (done || err)) begin
        check("stray_pulse", 32'({done, err}), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt),   32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_err"},   32'(err),   32'd0);
    check({tag, "_id"},    32'(id),    32'd0);
  endtask

  initial begin
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] tg;
    int                    w;
    int                    k;
    int                    ab;
    bit                    seen;

    rst    = 1'b1;
    req    = '0;
    target = '0;
    abort  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed: match at index 3, at index 0, invalid code.
    do_txn(2'b01, {4'b0000, 4'b0111}, -1);
    do_txn(2'b01, {4'b0000, 4'b0000}, -1);
    do_txn(2'b01, {4'b0000, 4'b0101}, -1);
    // Both requesting: grants alternate, latencies 2 and 8.
    do_txn(2'b11, {4'b1000, 4'b0001}, -1);
    do_txn(2'b11, {4'b1000, 4'b0001}, -1);
    do_txn(2'b11, {4'b1000, 4'b0001}, -1);
    // Abort two cycles into a run, then a normal request.
    do_txn(2'b01, {4'b0000, 4'b1000}, 2);
    do_txn(2'b10, {4'b1111, 4'b0000}, -1);

    // Reset in the middle of a run.
    w = rr_pick(2'b01);
    sb.push_back('{rid: w, kind: K_DONE, lat: 8, cnt: 4'b1000});
    m_ptr  = w;
    req    = 2'b01;
    target = {4'b0000, 4'b1000};
    seen   = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt != '0);
    end
    if (!seen) timeout("rst_grant_wait");
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrun_rst");
    sb.delete();
    m_ptr = NREQ - 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(2'b11, {4'b0011, 4'b1110}, -1);

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int s = 0; s < NREQ; s++)
        tg[s*WIDTH +: WIDTH] = $urandom_range(0, 1) ? jcode($urandom_range(0, NST - 1))
                                                    : WIDTH'($urandom);
      w  = rr_pick(r);
      k  = jindex(tg[w*WIDTH +: WIDTH]);
      ab = (k >= 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, k - 1) : -1;
      do_txn(r, tg, ab);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
